ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares port A of the 32x4 sequence RAM between two requesters: req 0 = sequence
//  writer (LFSR fill), req 1 = playback/compare reader. Round-robin arbitration,
//  optional burst lock, registered RAM command, read-valid tracking per requester.
//  Sits between the sequencer/playback blocks and the RAM instance.
// PARAMETERS
//  AW      5  address width (RAM depth 2**AW)
//  DW      4  data width
//  RD_LAT  2  edges from accepting edge to ram_q valid (RAM_Final timing), >=1
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  req[1:0]   in   2   request per requester, held with command until accepted
//  we[1:0]    in   2   1 = write, 0 = read, per requester
//  lock[1:0]  in   2   1 = keep ownership after this command
//  addr0/1    in   AW  command address per requester
//  wdata0/1   in   DW  write data per requester
//  gnt[1:0]   out  2   combinational grant; command accepted on edge with req&gnt
//  rvalid[1:0] out 2   read data valid for that requester, 1-cycle pulse
//  rdata      out  DW  = ram_q, shared; qualify with rvalid
//  ram_addr   out  AW  registered RAM address
//  ram_data   out  DW  registered RAM write data
//  ram_wren   out  1   registered RAM write enable
//  ram_q      in   DW  RAM read data
//  busy       out  1   1 while in OWN0/OWN1 or any read in flight
// BEHAVIOUR
//  Reset (async, rst=0): gnt=0, rvalid=0, ram_wren=0, ram_addr=0, ram_data=0,
//   busy=0, state=IDLE, rr pointer favours req 0. In-flight reads discarded.
//  FSM: IDLE, OWN0, OWN1.
//   IDLE: one req -> it is granted. Both -> the one not served last wins (rr).
//     Accept with lock=1 -> OWNx; lock=0 -> stay IDLE, rr points to other.
//   OWNx: only x can be granted; other requester waits (gnt=0).
//     Accept from x with lock=0 -> IDLE, rr points to other. x idle: stay OWNx.
//  gnt is one-hot or zero; never asserted without matching req. Grant is a
//   function of current req/state only (no dependence on we/addr).
//  Accepting edge: ram_addr<=addrX, ram_data<=wdataX, ram_wren<=weX.
//   No accept: ram_wren<=0, ram_addr/ram_data hold.
//  Throughput: one command per cycle; back-to-back from same requester allowed
//   (req held high, new command presented after each accepting edge).
//  Reads: RD_LAT-deep shift pipeline of {valid,id}; rvalid[id] pulses exactly
//   RD_LAT cycles after the accepting edge, rdata=ram_q in that cycle.
//   Writes never produce rvalid. Read-after-write same address returns new data
//   (RAM_Final ordering; arbiter adds no reordering).
//  Address wrap: none in arbiter; requesters own address arithmetic.
//  Reset mid-burst: ownership lost, pipeline cleared, no rvalid after release.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs gcnt0, gcnt1 [15:0], accepted commands per
//   requester, saturate at 16'hFFFF, cleared by reset; plus wait_max [7:0], longest
//   consecutive req-without-gnt run of either requester, saturating at 8'hFF.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Single writer: req0, we0=1, addr0=5'd3, wdata0=4'hA -> gnt0 same cycle;
//    next cycle ram_wren=1, ram_addr=3, ram_data=A; no rvalid.
//  2 Readback: after 1, req1 read addr1=3 -> rvalid1 exactly 2 cycles after
//    accept, rdata=4'hA; rvalid0 stays 0.
//  3 Contention, from reset: req0,req1 high, lock=0 continuous -> gnt alternates
//    0,1,0,1; each requester gets 50% over 32 cycles.
//  4 Lock: req0 32 writes addr 0..31, lock0=1 except last; req1 high throughout
//    -> gnt1=0 for 32 accepts, then gnt1 next cycle; busy=1 during burst.
//  5 Reset mid-operation: rst low 1 cycle with 2 reads in flight -> no rvalid
//    afterwards; state IDLE; ram_wren=0; req0 wins next tie.
//  6 ARB_STATS_EN: after test 3, gcnt0=16, gcnt1=16, wait_max=1.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares port A of the sequence RAM between two requesters:
//   requester 0 = sequence writer (LFSR fill), requester 1 = playback reader.
// Round-robin arbitration with optional burst lock, registered RAM command and
// per-requester read-valid tracking through a RD_LAT-deep {valid,id} pipeline.
//
// Optional feature macro: ARB_STATS_EN
//   When defined, adds the outputs gcnt0/gcnt1 (saturating accepted-command
//   counts per requester) and wait_max (longest req-without-gnt run, saturating).
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   req/we/lock[1:0] per-requester request, write flag, keep-ownership flag
//   addr0/addr1      per-requester command address
//   wdata0/wdata1    per-requester write data
//   gnt[1:0]         combinational grant, one-hot or zero
//   rvalid[1:0]      read data valid pulse for the requester that issued the read
//   rdata            shared read data (= ram_q), qualify with rvalid
//   ram_addr/ram_data/ram_wren  registered RAM command
//   ram_q            RAM read data
//   busy             ownership held or a read in flight
//   gcnt0/gcnt1/wait_max  statistics (ARB_STATS_EN only)
module ram_port_arbiter #(
  parameter int AW     = 5,
  parameter int DW     = 4,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [1:0]    lock,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1,
  output logic [7:0]    wait_max
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e              state_q;
  logic                rr_q;        // 1 = requester 1 wins the next tie
  logic [1:0]          gnt_d;
  logic                accept;
  logic                acc_id;
  logic [AW-1:0]       ram_addr_q;
  logic [DW-1:0]       ram_data_q;
  logic                ram_wren_q;
  logic [RD_LAT-1:0]   pv_q;        // read pipeline valid bits
  logic [RD_LAT-1:0]   pid_q;       // read pipeline requester ids
  logic [1:0]          rvalid_q;

  // Grant depends only on state, rr pointer and req; forced off during reset.
  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt_d = 2'b00;
    unique case (state_q)
      IDLE:    gnt_d = (req == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : req;
      OWN0:    gnt_d[0] = req[0];
      OWN1:    gnt_d[1] = req[1];
      default: gnt_d = 2'b00;
    endcase
    if (!rst) gnt_d = 2'b00;
  end

  assign accept = |gnt_d;
  assign acc_id = gnt_d[1];

  // Ownership FSM and round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else if (accept) begin
      if (lock[acc_id]) begin
        state_q <= acc_id ? OWN1 : OWN0;
      end else begin
        state_q <= IDLE;
        rr_q    <= ~acc_id;
      end
    end
  end

  // Registered RAM command; address/data hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
    end else begin
      ram_wren_q <= 1'b0;
      if (accept) begin
        ram_addr_q <= acc_id ? addr1 : addr0;
        ram_data_q <= acc_id ? wdata1 : wdata0;
        ram_wren_q <= we[acc_id];
      end
    end
  end

  // Read tracking: stage 0 loads on the accepting edge, the last stage feeds a
  // registered rvalid so the pulse lands RD_LAT edges after acceptance, the
  // cycle in which ram_q carries the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q     <= '0;
      pid_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      pv_q[0]  <= accept & ~we[acc_id];
      pid_q[0] <= acc_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
      rvalid_q <= {pv_q[RD_LAT-1] & pid_q[RD_LAT-1],
                   pv_q[RD_LAT-1] & ~pid_q[RD_LAT-1]};
    end
  end

  assign gnt      = gnt_d;
  assign rvalid   = rvalid_q;
  assign rdata    = ram_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign busy     = (state_q != IDLE) | (|pv_q);

`ifdef ARB_STATS_EN
  logic [15:0] gcnt0_q, gcnt1_q;
  logic [7:0]  wcnt0_q, wcnt1_q, wait_max_q;
  logic [7:0]  run0_d, run1_d, wmax_d;

  // Current wait-run length per requester including this cycle; 0 when not waiting.
  always_comb begin
    run0_d = 8'd0;
    run1_d = 8'd0;
    if (req[0] & ~gnt_d[0]) run0_d = (wcnt0_q == 8'hFF) ? 8'hFF : wcnt0_q + 8'd1;
    if (req[1] & ~gnt_d[1]) run1_d = (wcnt1_q == 8'hFF) ? 8'hFF : wcnt1_q + 8'd1;
    wmax_d = wait_max_q;
    if (run0_d > wmax_d) wmax_d = run0_d;
    if (run1_d > wmax_d) wmax_d = run1_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt0_q    <= '0;
      gcnt1_q    <= '0;
      wcnt0_q    <= '0;
      wcnt1_q    <= '0;
      wait_max_q <= '0;
    end else begin
      if (gnt_d[0] && gcnt0_q != 16'hFFFF) gcnt0_q <= gcnt0_q + 16'd1;
      if (gnt_d[1] && gcnt1_q != 16'hFFFF) gcnt1_q <= gcnt1_q + 16'd1;
      wcnt0_q    <= run0_d;
      wcnt1_q    <= run1_d;
      wait_max_q <= wmax_d;
    end
  end

  assign gcnt0    = gcnt0_q;
  assign gcnt1    = gcnt1_q;
  assign wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter. A behavioural model (owner / last
// served requester, a scoreboard memory and a queue of expected read returns)
// predicts gnt, the RAM command, busy and rvalid/rdata every cycle. A simple
// RAM with two edges of read latency sits on the RAM side of the arbiter.
module tb_ram_port_arbiter;
  localparam int AW     = 5;
  localparam int DW     = 4;
  localparam int RD_LAT = 2;

  logic          clk, rst;
  logic [1:0]    req, we, lock;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;
  logic          ram_wren, busy;
`ifdef ARB_STATS_EN
  logic [15:0]   gcnt0, gcnt1;
  logic [7:0]    wait_max;
`endif

  ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
`ifdef ARB_STATS_EN
    ,
    .gcnt0(gcnt0), .gcnt1(gcnt1), .wait_max(wait_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: write and address capture on the edge after the command is registered,
  // data out one edge later.
  logic [DW-1:0] ram_mem [2**AW];
  logic [DW-1:0] ram_q1;
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q1 <= ram_mem[ram_addr];
    ram_q  <= ram_q1;
  end

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  int            owner  = -1;
  int            last   = 1;
  logic [DW-1:0] model_mem [2**AW];
  rd_t           exp_q[$];
  logic          exp_wren;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [1:0]    last_gnt;

  function automatic logic [1:0] model_grant();
    if (owner == 0) return req[0] ? 2'b01 : 2'b00;
    if (owner == 1) return req[1] ? 2'b10 : 2'b00;
    if (req == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return req;
  endfunction

  // One clock cycle: entered just after a negedge with inputs driven,
  // returns at the next negedge.
  task automatic cycle();
    logic [1:0]    eg, erv;
    logic [DW-1:0] erd;
    logic          eb;
    int            id;
    rd_t           e;
    #1;
    eg = model_grant();
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg);
    end
    last_gnt = gnt;
    exp_wren = 1'b0;
    if (eg != 2'b00) begin
      id       = eg[1] ? 1 : 0;
      exp_wren = we[id];
      exp_addr = (id == 1) ? addr1 : addr0;
      exp_data = (id == 1) ? wdata1 : wdata0;
      if (we[id]) begin
        model_mem[exp_addr] = exp_data;
      end else begin
        e.due  = cyc + 1 + RD_LAT;
        e.id   = id;
        e.data = model_mem[exp_addr];
        exp_q.push_back(e);
      end
      if (lock[id]) owner = id;
      else begin
        owner = -1;
        last  = id;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    erv = 2'b00;
    erd = '0;
    eb  = (owner >= 0);
    foreach (exp_q[k]) begin
      if (exp_q[k].due == cyc) begin
        erv[exp_q[k].id] = 1'b1;
        erd = exp_q[k].data;
      end
      if (exp_q[k].due > cyc) eb = 1'b1;
    end
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
    checks++;
    if (ram_wren !== exp_wren) begin
      errors++;
      $display("FAIL ram_wren cyc=%0d got=%b exp=%b", cyc, ram_wren, exp_wren);
    end
    checks++;
    if (ram_addr !== exp_addr || ram_data !== exp_data) begin
      errors++;
      $display("FAIL ram_cmd cyc=%0d got=%0d/%h exp=%0d/%h", cyc, ram_addr, ram_data, exp_addr, exp_data);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
    end
    checks++;
    if (rvalid !== erv) begin
      errors++;
      $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, erv);
    end
    if (erv != 2'b00) begin
      checks++;
      if (rdata !== erd) begin
        errors++;
        $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, erd);
      end
    end
    @(negedge clk);
  endtask

  // One-cycle reset with both requests raised; outputs must be quiet at once.
  task automatic do_reset();
    req = 2'b11;
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b00 || ram_wren !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got gnt=%b rvalid=%b wren=%b busy=%b exp all 0", gnt, rvalid, ram_wren, busy);
    end
    checks++;
    if (ram_addr !== '0 || ram_data !== '0) begin
      errors++;
      $display("FAIL reset_cmd got addr=%0d data=%h exp 0/0", ram_addr, ram_data);
    end
    owner    = -1;
    last     = 1;
    exp_wren = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    req = 2'b00;
    repeat (2) cycle();
  endtask

  task automatic test_single_write();
    req = 2'b01; we = 2'b01; lock = 2'b00; addr0 = 5'd3; wdata0 = 4'hA;
    cycle();
    checks++;
    if (last_gnt !== 2'b01 || ram_wren !== 1'b1 || ram_addr !== 5'd3 || ram_data !== 4'hA) begin
      errors++;
      $display("FAIL single_write got gnt=%b wren=%b addr=%0d data=%h exp 01/1/3/a", last_gnt, ram_wren, ram_addr, ram_data);
    end
    req = 2'b00;
    cycle();
  endtask

  task automatic test_readback();
    req = 2'b10; we = 2'b00; addr1 = 5'd3; wdata1 = 4'h0;
    cycle();
    req = 2'b00;
    cycle();
    checks++;
    if (rvalid !== 2'b00) begin
      errors++;
      $display("FAIL readback_early got rvalid=%b exp 00", rvalid);
    end
    cycle();
    checks++;
    if (rvalid !== 2'b10 || rdata !== 4'hA) begin
      errors++;
      $display("FAIL readback got rvalid=%b rdata=%h exp 10/a", rvalid, rdata);
    end
    repeat (2) cycle();
  endtask

  task automatic test_contention();
    int n0 = 0, n1 = 0;
    do_reset();
    we = 2'b11; lock = 2'b00;
    for (int i = 0; i < 32; i++) begin
      req = 2'b11;
      addr0 = AW'($urandom); wdata0 = DW'($urandom);
      addr1 = AW'($urandom); wdata1 = DW'($urandom);
      cycle();
      checks++;
      if (last_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL alternate i=%0d got=%b exp=%b", i, last_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (last_gnt[0]) n0++;
      if (last_gnt[1]) n1++;
    end
    checks++;
    if (n0 != 16 || n1 != 16) begin
      errors++;
      $display("FAIL fair_share got %0d/%0d exp 16/16", n0, n1);
    end
`ifdef ARB_STATS_EN
    checks++;
    if (gcnt0 !== 16'd16 || gcnt1 !== 16'd16 || wait_max !== 8'd1) begin
      errors++;
      $display("FAIL stats got %0d/%0d/%0d exp 16/16/1", gcnt0, gcnt1, wait_max);
    end
`endif
    req = 2'b00;
    cycle();
  endtask

  // Requester 0 fills every address under lock while requester 1 waits.
  task automatic test_lock();
    int acc = 0, n1 = 0;
    do_reset();
    for (int n = 0; n < 40 && acc < 32; n++) begin
      req = 2'b11; we = 2'b01;
      lock = (acc != 31) ? 2'b01 : 2'b00;
      addr0 = AW'(acc); wdata0 = DW'($urandom);
      addr1 = 5'd7;
      cycle();
      if (last_gnt[1]) n1++;
      if (last_gnt[0]) acc++;
    end
    checks++;
    if (acc != 32 || n1 != 0) begin
      errors++;
      $display("FAIL lock_burst got accepts=%0d gnt1=%0d exp 32/0", acc, n1);
    end
    lock = 2'b00;
    cycle();
    checks++;
    if (last_gnt !== 2'b10) begin
      errors++;
      $display("FAIL lock_release got gnt=%b exp 10", last_gnt);
    end
    req = 2'b00;
    repeat (3) cycle();
  endtask

  task automatic test_reset_mid();
    req = 2'b10; we = 2'b00; lock = 2'b00; addr1 = 5'd5;
    cycle();
    addr1 = 5'd9;
    cycle();
    do_reset();
    req = 2'b11; we = 2'b00; lock = 2'b00; addr0 = 5'd1; addr1 = 5'd2;
    cycle();
    checks++;
    if (last_gnt !== 2'b01) begin
      errors++;
      $display("FAIL reset_tie got gnt=%b exp 01", last_gnt);
    end
    req = 2'b00;
    repeat (4) cycle();
  endtask

  task automatic new_cmd(input int i);
    we[i]   = 1'($urandom_range(0, 1));
    lock[i] = ($urandom_range(0, 3) == 0);
    if (i == 0) begin
      addr0 = AW'($urandom); wdata0 = DW'($urandom);
    end else begin
      addr1 = AW'($urandom); wdata1 = DW'($urandom);
    end
  endtask

  // Random held commands, including back-to-back commands and random locks.
  task automatic test_random();
    logic [1:0] pend = 2'b00;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 7) begin
          pend[i] = 1'b1;
          new_cmd(i);
        end
      end
      req = pend;
      cycle();
      pend = pend & ~last_gnt;
    end
    req = 2'b00;
    repeat (RD_LAT + 2) cycle();
  endtask

  initial begin
    rst = 1'b0;
    req = 2'b00; we = 2'b00; lock = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_readback();
    test_contention();
    test_lock();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
